// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared IF-stage definitions.
//   if_state_e       - fetch FSM state encoding (IDLE/REQ/HOLD)
//   NOP              - instruction value shown when IF/ID holds nothing valid
//   DEFAULT_RESET_PC - default address of the first fetch after reset
package inst_fetch_pkg;
    typedef enum logic [1:0] {IF_IDLE = 2'd0, IF_REQ = 2'd1, IF_HOLD = 2'd2} if_state_e;
    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: instruction-memory req/ack bus.
//   req   - fetch request, held with addr until ack
//   addr  - fetch word address
//   ack   - request accepted, rdata valid this cycle (may coincide with req rising)
//   rdata - fetched instruction
//   master: fetch side, slave: memory side
interface inst_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    modport master (output req, addr, input ack, rdata);
    modport slave (input req, addr, output ack, rdata);
endinterface

// File: rtl/inst_fetch_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load/hold/clear controls.
//   clk, rst      - clock, synchronous active-high reset
//   load          - capture inst_d/pc_d and mark valid (wins over clear)
//   clear         - invalidate and show NOP_INST; pc is kept
//   inst_d, pc_d  - incoming instruction and its PC
//   inst, pc      - registered instruction and PC
//   valid         - registered contents valid
//   neither load nor clear: hold
module if_id_reg
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] inst_d,
    input  logic [31:0] pc_d,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        valid
);
    always_ff @(posedge clk) begin
        if (rst) begin
            inst  <= NOP_INST;
            pc    <= 32'd0;
            valid <= 1'b0;
        end else if (load) begin
            inst  <= inst_d;
            pc    <= pc_d;
            valid <= 1'b1;
        end else if (clear) begin
            inst  <= NOP_INST;
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: MIPS32 instruction-fetch stage (PC, imem handshake, IF/ID register).
//   clk, rst       - clock, synchronous active-high reset
//   stall          - downstream stall; IF/ID holds while high
//   branch_enable  - redirect for the instruction on inst (honoured if valid and not stalled)
//   branch_addr    - redirect target (bits [1:0] forced to 0)
//   imem           - instruction-memory bus (inst_fetch_if.master)
//   inst, pc       - IF/ID instruction and PC
//   inst_valid     - IF/ID contents valid
//   fetch_addr_err - only with FETCH_ALIGN_CHECK_EN: one-cycle pulse on a misaligned honoured target
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INST = NOP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_enable,
    input  logic [31:0]        branch_addr,
    inst_fetch_if.master       imem,
    output logic [31:0]        inst,
    output logic [31:0]        pc,
    output logic               inst_valid
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic               fetch_addr_err
`endif
);
    if_state_e   state;
    logic        req_q, redir_pend, take, ack, load, clear;
    logic [31:0] pc_q, hold_inst, hold_pc, redir_addr, target, next_pc;

    // The branch belongs to the instruction on inst; the delay slot is the one being fetched
    // (or already parked in the hold buffer), so only the fetch after it is redirected.
    assign take    = branch_enable && inst_valid && !stall;
    assign target  = {branch_addr[31:2], 2'b00};
    assign ack     = state == IF_REQ && imem.ack;
    assign next_pc = take ? target : redir_pend ? redir_addr : pc_q + 32'd4;
    assign load    = !stall && (ack || state == IF_HOLD);
    // A consumed instruction with no replacement must not be re-issued to decode.
    assign clear   = !stall && state == IF_REQ && !imem.ack;

    assign imem.req  = req_q;
    assign imem.addr = pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IF_IDLE;
            req_q      <= 1'b0;
            pc_q       <= RESET_PC;
            redir_pend <= 1'b0;
            redir_addr <= 32'd0;
            hold_inst  <= NOP_INST;
            hold_pc    <= 32'd0;
        end else if (state == IF_IDLE) begin
            state <= IF_REQ;
            req_q <= 1'b1;
        end else if (ack) begin
            pc_q       <= next_pc;
            redir_pend <= 1'b0;
            if (stall) begin
                state     <= IF_HOLD;
                req_q     <= 1'b0;
                hold_inst <= imem.rdata;
                hold_pc   <= pc_q;
            end
        end else if (state == IF_REQ) begin
            // Request stays up; remember the redirect until the delay slot returns.
            if (take) begin
                redir_pend <= 1'b1;
                redir_addr <= target;
            end
        end else if (!stall) begin
            state <= IF_REQ;
            req_q <= 1'b1;
            if (take)
                pc_q <= target;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)
            fetch_addr_err <= 1'b0;
        else
            fetch_addr_err <= take && |branch_addr[1:0];
    end
`endif

    if_id_reg #(.NOP_INST(NOP_INST)) u_if_id (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .clear  (clear),
        .inst_d (state == IF_HOLD ? hold_inst : imem.rdata),
        .pc_d   (state == IF_HOLD ? hold_pc : pc_q),
        .inst   (inst),
        .pc     (pc),
        .valid  (inst_valid)
    );
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed self-checking bench for inst_fetch with a latency-programmable memory model.
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        rst, stall, br_en, valid, force_ack;
    logic [31:0] br_addr, inst, pc;
    int          lat, cnt, vectors, miscompares;
    int          n108 = 0;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        err;
`endif

    inst_fetch_if bus();

    inst_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_enable (br_en),
        .branch_addr   (br_addr),
        .imem          (bus),
        .inst          (inst),
        .pc            (pc),
        .inst_valid    (valid)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_addr_err(err)
`endif
    );

    always #5 clk = ~clk;

    // Memory: ack once req has been up for lat cycles; force_ack injects a stray ack.
    assign bus.ack   = (bus.req && cnt >= lat) || force_ack;
    assign bus.rdata = bus.addr ^ 32'hA5A5_0000;

    always @(posedge clk) begin
        cnt <= (rst || !bus.req || bus.ack) ? 0 : cnt + 1;
        if (bus.req && bus.addr == 32'h108)
            n108 <= n108 + 1;
    end

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; br_en = 1'b0; br_addr = 32'd0; lat = 0; force_ack = 1'b0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        do_reset();
        rst = 1'b1;
        step();
        check("rst_req", bus.req, 0);
        check("rst_addr", bus.addr, 0);
        check("rst_inst", inst, 0);
        check("rst_pc", pc, 0);
        check("rst_valid", valid, 0);
`ifdef FETCH_ALIGN_CHECK_EN
        check("rst_err", err, 0);
`endif
        rst = 1'b0;
        // zero-wait stream
        step(); check("zw_req", bus.req, 1); check("zw_valid0", valid, 0);
        step(); check("zw_pc0", pc, 0); check("zw_valid1", valid, 1); check("zw_inst0", inst, word(0));
        step(); check("zw_pc4", pc, 4);
        step(); check("zw_pc8", pc, 8);
        step(); check("zw_pc12", pc, 12); check("zw_inst12", inst, word(12));

        // ack delayed on addr 8, then stall over the addr-12 ack, then reset mid-request
        do_reset();
        step(); step(); step();
        lat = 2;
        check("dl_pc4", pc, 4); check("dl_req1", bus.req, 1); check("dl_addr1", bus.addr, 8);
        step(); check("dl_req2", bus.req, 1); check("dl_addr2", bus.addr, 8);
        check("dl_valid2", valid, 0); check("dl_nop", inst, 0);
        step(); check("dl_req3", bus.req, 1); check("dl_addr3", bus.addr, 8); check("dl_valid3", valid, 0);
        lat = 0;
        step(); check("dl_pc8", pc, 8); check("dl_valid", valid, 1); check("dl_inst8", inst, word(8));
        stall = 1'b1;
        step(); check("st_req1", bus.req, 0); check("st_pc1", pc, 8); check("st_inst1", inst, word(8));
        step(); check("st_req2", bus.req, 0); check("st_inst2", inst, word(8));
        stall = 1'b0;
        step(); check("st_pc12", pc, 12); check("st_inst12", inst, word(12));
        check("st_req", bus.req, 1); check("st_addr16", bus.addr, 16);
        lat = 5;
        step(); check("mr_valid", valid, 0); check("mr_addr", bus.addr, 16);
        rst = 1'b1; force_ack = 1'b1;
        step(); check("mr_req", bus.req, 0); check("mr_addr0", bus.addr, 0);
        check("mr_pc", pc, 0); check("mr_inst", inst, 0); check("mr_valid0", valid, 0);
        rst = 1'b0;
        step(); check("mr_stale", valid, 0); check("mr_req1", bus.req, 1); check("mr_addr1", bus.addr, 0);
        force_ack = 1'b0; lat = 0;
        step(); check("mr_pc0", pc, 0); check("mr_valid1", valid, 1); check("mr_inst0", inst, word(0));

        // zero-wait jumps: 4 -> 0x100, then 0x100 -> 0x400
        do_reset();
        step(); step(); step();
        check("jz_pc4", pc, 4);
        br_en = 1'b1; br_addr = 32'h100;
        step(); check("jz_slot8", pc, 8); check("jz_addr100", bus.addr, 32'h100);
        br_en = 1'b0;
        step(); check("jz_pc100", pc, 32'h100);
        br_en = 1'b1; br_addr = 32'h400;
        step(); check("jz_slot104", pc, 32'h104); check("jz_addr400", bus.addr, 32'h400);
        br_en = 1'b0;
        step(); check("jz_pc400", pc, 32'h400); check("jz_inst400", inst, word(32'h400));
        step(); check("jz_pc404", pc, 32'h404);

        // jump at 0x100 with delay-slot ack delayed 2 cycles
        do_reset();
        step(); step(); step();
        br_en = 1'b1; br_addr = 32'h100;
        step(); br_en = 1'b0;
        step(); check("jd_pc100", pc, 32'h100);
        br_en = 1'b1; br_addr = 32'h400; lat = 2;
        step(); br_en = 1'b0;
        check("jd_valid0", valid, 0); check("jd_req", bus.req, 1); check("jd_addr104", bus.addr, 32'h104);
        step(); check("jd_addr104b", bus.addr, 32'h104);
        step(); check("jd_slot104", pc, 32'h104); check("jd_valid1", valid, 1); check("jd_addr400", bus.addr, 32'h400);
        lat = 0;
        step(); check("jd_pc400", pc, 32'h400);
        step(); check("jd_pc404", pc, 32'h404);
        check("jd_no108", n108, 0);

        // PC wrap at the top of the address space
        do_reset();
        step(); step(); check("wr_pc0", pc, 0);
        br_en = 1'b1; br_addr = 32'hFFFF_FFFC;
        step(); br_en = 1'b0;
        check("wr_slot4", pc, 4); check("wr_addrtop", bus.addr, 32'hFFFF_FFFC);
        step(); check("wr_pctop", pc, 32'hFFFF_FFFC); check("wr_addr0", bus.addr, 0);
        step(); check("wr_pc0b", pc, 0); check("wr_inst0", inst, word(0));

        // misaligned target is forced to a word address
        do_reset();
        step(); step();
        br_en = 1'b1; br_addr = 32'h402;
        step(); br_en = 1'b0;
        check("al_addr400", bus.addr, 32'h400);
`ifdef FETCH_ALIGN_CHECK_EN
        check("al_err1", err, 1);
`endif
        step(); check("al_pc400", pc, 32'h400);
`ifdef FETCH_ALIGN_CHECK_EN
        check("al_err0", err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
